// File: rtl/imem_rom.sv
// Instruction-memory slave for the cpu_top fetch port: word-addressed program
// array, fixed-latency pipelined reads, credit flow control and a response FIFO.
module imem_rom #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 1,
  parameter int RESP_DEPTH  = 2,
  localparam int AW         = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          imem_req_valid,
  input  logic [31:0]   imem_req_addr,
  output logic          imem_req_ready,
  output logic          imem_resp_valid,
  output logic [31:0]   imem_resp_data,
  output logic          imem_resp_err,
  input  logic          imem_resp_ready,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [31:0]   prog_wdata
);

  localparam int PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int CW = $clog2(RESP_DEPTH + 1);

  logic [31:0]        mem [DEPTH_WORDS];

  logic               accept;
  logic               push;
  logic               pop;
  logic [AW-1:0]      req_index;
  logic               req_err;
  logic [31:0]        req_word;

  logic [CW-1:0]      outstanding;

  logic [LATENCY-1:0] stg_valid;
  logic [LATENCY-1:0] stg_err;
  logic [31:0]        stg_data [LATENCY];

  logic [31:0]        fifo_data [RESP_DEPTH];
  logic               fifo_err  [RESP_DEPTH];
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic [CW-1:0]      fifo_count;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RESP_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign accept    = imem_req_valid && imem_req_ready;
  assign pop       = imem_resp_valid && imem_resp_ready;
  assign push      = stg_valid[LATENCY-1];

  // Anything outside the word array or not word-aligned answers with an error and zero data.
  assign req_index = imem_req_addr[AW+1:2];
  assign req_err   = (imem_req_addr[1:0] != 2'b00) || ((imem_req_addr >> (AW + 2)) != 32'd0);
  assign req_word  = req_err ? 32'h0000_0000 : mem[req_index];

  // Program load is independent of reset and of the fetch handshake.
  always_ff @(posedge clk) begin
    if (prog_we) begin
      mem[prog_addr] <= prog_wdata;
    end
  end

  // Credits cover every response that is in the pipeline or waiting in the FIFO.
  always_ff @(posedge clk) begin
    if (reset) begin
      outstanding <= '0;
    end else begin
      case ({accept, pop})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  assign imem_req_ready = (outstanding < CW'(RESP_DEPTH));

  // First stage is the array read register; capturing the word here gives read-first
  // behaviour when a program write hits the same index on the accept edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      stg_valid[0] <= 1'b0;
    end else begin
      stg_valid[0] <= accept;
    end
  end

  always_ff @(posedge clk) begin
    stg_data[0] <= req_word;
    stg_err[0]  <= req_err;
  end

  generate
    for (genvar g = 1; g < LATENCY; g++) begin : g_stage
      always_ff @(posedge clk) begin
        if (reset) begin
          stg_valid[g] <= 1'b0;
        end else begin
          stg_valid[g] <= stg_valid[g-1];
        end
      end

      always_ff @(posedge clk) begin
        stg_data[g] <= stg_data[g-1];
        stg_err[g]  <= stg_err[g-1];
      end
    end
  endgenerate

  // Pipeline never stalls: the credit limit guarantees a free slot for every push.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= stg_data[LATENCY-1];
      fifo_err[wr_ptr]  <= stg_err[LATENCY-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Head is gated so the response bus reads zero whenever the FIFO is empty.
  assign imem_resp_valid = (fifo_count != '0);
  assign imem_resp_data  = imem_resp_valid ? fifo_data[rd_ptr] : 32'h0000_0000;
  assign imem_resp_err   = imem_resp_valid && fifo_err[rd_ptr];

endmodule

// File: tb/tb_imem_rom.sv
// Bench for imem_rom: directed scenarios with literal expectations plus a randomized
// phase, all checked every cycle against a queue-based model of the fetch port.
module tb_imem_rom;

  localparam int DW  = 256;
  localparam int LAT = 2;
  localparam int RD  = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        imem_resp_err;
  logic        imem_resp_ready;
  logic        prog_we;
  logic [7:0]  prog_addr;
  logic [31:0] prog_wdata;

  always #5 clk = ~clk;

  imem_rom #(
    .DEPTH_WORDS(DW),
    .LATENCY    (LAT),
    .RESP_DEPTH (RD)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .imem_resp_err  (imem_resp_err),
    .imem_resp_ready(imem_resp_ready),
    .prog_we        (prog_we),
    .prog_addr      (prog_addr),
    .prog_wdata     (prog_wdata)
  );

  int n_compared   = 0;
  int n_mismatched = 0;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // Model: every accepted request is a queue entry that becomes visible LAT edges later;
  // the queue length is the number of requests owed, which bounds acceptance.
  typedef struct {
    logic [31:0] data;
    logic        err;
    longint      due;
  } resp_t;

  resp_t       q[$];
  logic [31:0] mem_m [DW];
  longint      cyc         = 0;
  bit          live        = 0;
  bit          after_reset = 0;

  always @(posedge clk) begin : model
    resp_t r;
    bit    exp_v;
    bit    acc;
    exp_v = live && (q.size() > 0) && (q[0].due <= cyc);
    acc   = imem_req_valid && (q.size() < RD);
    cyc++;
    if (reset) begin
      q.delete();
      live        = 1;
      after_reset = 1;
    end else if (live) begin
      after_reset = 0;
      if (exp_v && imem_resp_ready) begin
        q.delete(0);
      end
      if (acc) begin
        r.err  = (imem_req_addr % 4 != 0) || (imem_req_addr >= 4 * DW);
        r.data = 32'h0;
        if (!r.err) begin
          r.data = mem_m[imem_req_addr / 4];
        end
        r.due = cyc + LAT;
        q.push_back(r);
      end
    end
    if (prog_we) begin
      mem_m[prog_addr] = prog_wdata;
    end
  end

  always @(posedge clk) begin : compare
    bit exp_v;
    #1;
    if (live) begin
      exp_v = (q.size() > 0) && (q[0].due <= cyc);
      check_output("req_ready", {31'b0, imem_req_ready}, {31'b0, q.size() < RD});
      check_output("resp_valid", {31'b0, imem_resp_valid}, {31'b0, exp_v});
      if (exp_v) begin
        check_output("resp_data", imem_resp_data, q[0].data);
        check_output("resp_err", {31'b0, imem_resp_err}, {31'b0, q[0].err});
      end
      if (after_reset) begin
        check_output("reset_data", imem_resp_data, 32'h0);
        check_output("reset_err", {31'b0, imem_resp_err}, 32'h0);
      end
    end
  end

  task automatic drain();
    int k;
    @(negedge clk);
    imem_req_valid  = 1'b0;
    imem_resp_ready = 1'b1;
    for (k = 0; k < 50; k++) begin
      if (q.size() == 0) break;
      @(negedge clk);
    end
    check_output("drain_done", {31'b0, q.size() == 0}, 32'h1);
  endtask

  task automatic apply_stimulus(input logic [31:0] addr, input logic [31:0] exp_d, input logic exp_e, input string name);
    int k;
    drain();
    @(negedge clk);
    imem_req_valid  = 1'b1;
    imem_req_addr   = addr;
    imem_resp_ready = 1'b1;
    check_output({name, "_ready"}, {31'b0, imem_req_ready}, 32'h1);
    @(negedge clk);
    imem_req_valid = 1'b0;
    imem_req_addr  = 32'hxxxx_xxxx;
    for (k = 0; k < 20; k++) begin
      if (imem_resp_valid) break;
      @(negedge clk);
    end
    check_output({name, "_latency"}, k, LAT);
    check_output({name, "_valid"}, {31'b0, imem_resp_valid}, 32'h1);
    check_output({name, "_data"}, imem_resp_data, exp_d);
    check_output({name, "_err"}, {31'b0, imem_resp_err}, {31'b0, exp_e});
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin : stimulus
    logic [31:0] prog [3];
    int          k;
    prog[0] = 32'h0050_0093;
    prog[1] = 32'h0070_0113;
    prog[2] = 32'h0020_81B3;

    reset           = 1'b1;
    imem_req_valid  = 1'b0;
    imem_req_addr   = 32'h0;
    imem_resp_ready = 1'b0;
    prog_we         = 1'b0;
    prog_addr       = 8'h0;
    prog_wdata      = 32'h0;

    // Program load runs while reset is held.
    for (int i = 0; i < DW; i++) begin
      @(negedge clk);
      prog_we    = 1'b1;
      prog_addr  = 8'(i);
      prog_wdata = (i < 3) ? prog[i] : $urandom;
    end
    @(negedge clk);
    prog_we = 1'b0;
    @(negedge clk);
    check_output("post_reset_valid", {31'b0, imem_resp_valid}, 32'h0);
    check_output("post_reset_ready", {31'b0, imem_req_ready}, 32'h1);
    reset = 1'b0;

    apply_stimulus(32'h0000_0000, 32'h0050_0093, 1'b0, "fetch0");
    apply_stimulus(32'h0000_0008, 32'h0020_81B3, 1'b0, "fetch8");
    apply_stimulus(32'h0000_0002, 32'h0000_0000, 1'b1, "misaligned");
    apply_stimulus(32'h0000_0400, 32'h0000_0000, 1'b1, "out_of_range");
    apply_stimulus(32'h0000_03FC, mem_m[255], 1'b0, "last_word");

    // Backpressure: fill every credit, then the head must hold while unread.
    drain();
    imem_resp_ready = 1'b0;
    for (int i = 0; i < RD; i++) begin
      @(negedge clk);
      imem_req_valid = 1'b1;
      imem_req_addr  = 32'(4 * (i % 3));
      check_output("bp_ready_open", {31'b0, imem_req_ready}, 32'h1);
    end
    @(negedge clk);
    imem_req_addr = 32'h0;
    for (int j = 0; j < 4; j++) begin
      check_output("bp_ready_closed", {31'b0, imem_req_ready}, 32'h0);
      check_output("bp_head_valid", {31'b0, imem_resp_valid}, 32'h1);
      check_output("bp_head_data", imem_resp_data, 32'h0050_0093);
      @(negedge clk);
    end
    imem_resp_ready = 1'b1;
    check_output("bp_pop0", imem_resp_data, 32'h0050_0093);
    @(negedge clk);
    check_output("bp_pop1", imem_resp_data, 32'h0070_0113);
    check_output("bp_reopen", {31'b0, imem_req_ready}, 32'h1);
    @(negedge clk);
    imem_req_valid = 1'b0;
    check_output("bp_pop2", imem_resp_data, 32'h0020_81B3);

    // Same-edge program write and fetch of index 1 must return the old word.
    drain();
    @(negedge clk);
    prog_we        = 1'b1;
    prog_addr      = 8'd1;
    prog_wdata     = 32'hDEAD_BEEF;
    imem_req_valid = 1'b1;
    imem_req_addr  = 32'h4;
    check_output("collide_ready", {31'b0, imem_req_ready}, 32'h1);
    @(negedge clk);
    prog_we        = 1'b0;
    imem_req_valid = 1'b0;
    for (k = 0; k < 20; k++) begin
      if (imem_resp_valid) break;
      @(negedge clk);
    end
    check_output("collide_old", imem_resp_data, 32'h0070_0113);
    apply_stimulus(32'h0000_0004, 32'hDEAD_BEEF, 1'b0, "collide_new");

    // Reset with responses queued discards them but keeps memory.
    drain();
    imem_resp_ready = 1'b0;
    @(negedge clk);
    imem_req_valid = 1'b1;
    imem_req_addr  = 32'h0;
    @(negedge clk);
    imem_req_addr  = 32'h8;
    @(negedge clk);
    imem_req_valid = 1'b0;
    for (k = 0; k < 20; k++) begin
      if (q.size() == 2 && q[1].due <= cyc) break;
      @(negedge clk);
    end
    check_output("queued_two", {31'b0, imem_resp_valid}, 32'h1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_output("rst_valid", {31'b0, imem_resp_valid}, 32'h0);
    check_output("rst_ready", {31'b0, imem_req_ready}, 32'h1);
    check_output("rst_data", imem_resp_data, 32'h0);
    imem_resp_ready = 1'b1;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      check_output("no_stale", {31'b0, imem_resp_valid}, 32'h0);
    end
    apply_stimulus(32'h0000_0000, 32'h0050_0093, 1'b0, "retained");

    // Randomized traffic, program writes and occasional resets.
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      reset          = ($urandom_range(0, 99) == 0);
      imem_req_valid = ($urandom_range(0, 9) < 7);
      case ($urandom_range(0, 9))
        0:       imem_req_addr = $urandom;
        1:       imem_req_addr = (32'($urandom_range(0, DW - 1)) << 2) | 32'($urandom_range(1, 3));
        default: imem_req_addr = 32'($urandom_range(0, DW - 1)) << 2;
      endcase
      imem_resp_ready = ($urandom_range(0, 9) < 7);
      prog_we         = ($urandom_range(0, 9) == 0);
      prog_addr       = 8'($urandom_range(0, DW - 1));
      prog_wdata      = $urandom;
    end
    @(negedge clk);
    reset   = 1'b0;
    prog_we = 1'b0;
    drain();
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
